ps2_keycode_ctrl: RTL and testbench
===================================

# ps2_keycode_ctrl

Scan-code sequencer that sits directly after the PS/2 frame receiver. It consumes validated 8-bit scan-code bytes and tracks the Set-2 prefix sequences (0xE0 extended, 0xF0 break, 0xE1 pause). It emits one complete key event per physical key action into a small event FIFO, drained by the display/game logic through a valid/ready handshake. Protocol bytes and malformed frames are filtered out here, so downstream logic only sees key events.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000, idle clk cycles after which a partial prefix sequence is abandoned.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- byte_valid  input  1  single-cycle strobe: byte_data/parity_ok valid.
- byte_data  input  8  received scan-code byte, bit 7 MSB.
- parity_ok  input  1  odd parity of frame checked good.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready.
- evt_code  output  8  key code of head event (prefix bytes stripped).
- evt_break  output  1  1 = key release, 0 = key press.
- evt_extended  output  1  1 = code was preceded by 0xE0 (or is pause).
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- ovf_clear  input  1  clears overflow (lower priority than a same-cycle set).
- drop_count  output  8  saturating count of discarded bytes/events (parity error, FIFO full, unknown protocol bytes).

## Operation
- Decoder FSM states: IDLE, EXT (got E0), BRK (got F0), EXT_BRK (got E0 F0), PAUSE (inside E1 sequence).
- All transitions happen only on byte_valid, except the timeout.
- IDLE:
  - 0xE0 -> EXT.
  - 0xF0 -> BRK.
  - 0xE1 -> PAUSE with pause counter = 7.
  - 0xAA, 0xFA, 0xEE, 0xFE -> stay in IDLE, discard silently.
  - 0x00, 0xFF -> discard, drop_count+1.
  - Any other byte -> push {code, break=0, ext=0}.
- EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay; any other byte -> push {code, 0, 1}, then IDLE.
- BRK: any byte except prefixes -> push {code, 1, 0}, then IDLE. A prefix byte here -> IDLE, drop_count+1.
- EXT_BRK: non-prefix byte -> push {code, 1, 1}, then IDLE. Prefix byte -> IDLE, drop_count+1.
- PAUSE: each byte decrements the counter; at 0 -> push {0xE1, 0, 1}, then IDLE. Byte contents are not checked.
- Parity error (byte_valid & !parity_ok) in any state: byte ignored, FSM -> IDLE, drop_count+1.
- Timeout: counter reloads on every byte_valid. In any state other than IDLE, when it reaches TIMEOUT_CYCLES the FSM -> IDLE. No event is emitted and drop_count is unchanged.
- FIFO:
  - First-word-fall-through, registered outputs.
  - Push when full -> event dropped, overflow <= 1, drop_count+1.
  - Push and pop in the same cycle while full -> both succeed; no overflow.
  - Pop when empty is ignored.
- drop_count saturates at 0xFF. Multiple increment causes in one cycle count once.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty.
  - evt_valid = 0, evt_code = 0x00, evt_break = 0, evt_extended = 0.
  - overflow = 0, drop_count = 0, timeout counter = 0.
- Latency: terminal byte strobed at cycle N -> evt_valid = 1 at N+1 if the FIFO was empty.
- evt_* remain stable while evt_valid & !evt_ready.
- After a pop at cycle N, the next entry is presented at N+1. evt_valid falls at N+1 if the FIFO is now empty.
- Throughput: one byte per cycle accepted; no backpressure on byte_valid.
- reset mid-sequence or with the FIFO non-empty: all state is cleared at the next posedge. Bytes strobed in the reset cycle are ignored.

## Test plan
- Byte 0x1C -> one event {0x1C, break 0, ext 0}; evt_valid rises 1 cycle after the strobe.
- Bytes F0, 1C -> {0x1C, 1, 0}. Bytes E0, F0, 75 -> {0x75, 1, 1}. No event after an E0 alone.
- E1, 14, 77, E1, F0, 14, F0, 77 -> exactly one event {0xE1, 0, 1}.
- With evt_ready = 0, send 5 make codes (FIFO_DEPTH = 4): first 4 retained in order, overflow = 1, drop_count = 1. Pulse ovf_clear -> overflow = 0.
- Send E0, then idle TIMEOUT_CYCLES, then 0x74 -> {0x74, 0, 0}. Send F0 with parity_ok = 0, then 0x1C -> {0x1C, 0, 0}, drop_count = 1.
- Bytes 0xAA and 0xFA -> no event, drop_count unchanged. Assert reset after an F0 -> the following 0x1C decodes as a make.

Source files
------------

// File: rtl/ps2_keycode_ctrl.sv
// PS/2 Set-2 scan-code sequencer: folds E0/F0/E1 prefix sequences into single
// key events and queues them in a small first-word-fall-through event FIFO.
module ps2_keycode_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       parity_ok,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_extended,
  output logic       overflow,
  input  logic       ovf_clear,
  output logic [7:0] drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    pause_cnt, pause_cnt_nxt;
  logic [TW-1:0] idle_cnt, idle_cnt_nxt;
  logic          push;
  logic [9:0]    push_data;
  logic          fsm_drop;
  logic          is_prefix;
  logic          is_ack;

  assign is_prefix = (byte_data == 8'hE0) || (byte_data == 8'hF0) || (byte_data == 8'hE1);
  assign is_ack    = (byte_data == 8'hAA) || (byte_data == 8'hFA) ||
                     (byte_data == 8'hEE) || (byte_data == 8'hFE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pause_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = pause_cnt;
    idle_cnt_nxt  = idle_cnt;
    push          = 1'b0;
    push_data     = {byte_data, 1'b0, 1'b0};
    fsm_drop      = 1'b0;
    if (byte_valid) begin
      idle_cnt_nxt = '0;
      if (!parity_ok) begin
        state_nxt = S_IDLE;
        fsm_drop  = 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (byte_data == 8'hE0) begin
              state_nxt = S_EXT;
            end else if (byte_data == 8'hF0) begin
              state_nxt = S_BRK;
            end else if (byte_data == 8'hE1) begin
              state_nxt     = S_PAUSE;
              pause_cnt_nxt = 3'd7;
            end else if (is_ack) begin
              state_nxt = S_IDLE;
            end else if ((byte_data == 8'h00) || (byte_data == 8'hFF)) begin
              fsm_drop = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          S_EXT: begin
            if (byte_data == 8'hF0) begin
              state_nxt = S_EXT_BRK;
            end else if (byte_data != 8'hE0) begin
              push      = 1'b1;
              push_data = {byte_data, 1'b0, 1'b1};
              state_nxt = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_nxt = S_IDLE;
            if (is_prefix) begin
              fsm_drop = 1'b1;
            end else begin
              push      = 1'b1;
              push_data = {byte_data, 1'b1, state == S_EXT_BRK};
            end
          end
          S_PAUSE: begin
            // The E1 sequence is eight bytes long; only its length matters.
            if (pause_cnt == 3'd1) begin
              push      = 1'b1;
              push_data = {8'hE1, 1'b0, 1'b1};
              state_nxt = S_IDLE;
            end
            pause_cnt_nxt = pause_cnt - 3'd1;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end else if (state != S_IDLE) begin
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nxt    = S_IDLE;
        idle_cnt_nxt = '0;
      end else begin
        idle_cnt_nxt = idle_cnt + TW'(1);
      end
    end
  end

  // Shift-register FIFO: entry 0 is the head, so the outputs come straight from flops.
  logic [9:0]    mem [FIFO_DEPTH];
  logic [CW-1:0] count, count_nxt, wr_idx;
  logic          pop, full, do_push, fifo_drop;

  assign pop       = evt_valid & evt_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign do_push   = push & (!full | pop);
  assign fifo_drop = push & full & !pop;
  assign wr_idx    = pop ? count - CW'(1) : count;
  assign count_nxt = count + CW'(do_push) - CW'(pop);

  assign evt_code     = mem[0][9:2];
  assign evt_break    = mem[0][1];
  assign evt_extended = mem[0][0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      count      <= '0;
      evt_valid  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        if (pop) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (do_push && (wr_idx == CW'(i))) mem[i] <= push_data;
      end
      count     <= count_nxt;
      evt_valid <= (count_nxt != '0);
      if (fifo_drop) overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      if ((fsm_drop || fifo_drop) && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ps2_keycode_ctrl.sv
// Testbench for ps2_keycode_ctrl: directed scenarios plus a randomized run
// compared against a prefix-history / event-queue reference model.
module tb_ps2_keycode_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       parity_ok = 1'b1;
  logic       evt_ready = 1'b0;
  logic       ovf_clear = 1'b0;
  logic       evt_valid, evt_break, evt_extended, overflow;
  logic [7:0] evt_code, drop_count;

  int checks = 0;
  int errors = 0;

  logic [9:0] m_q[$];
  logic [7:0] m_pend[$];
  bit         m_ovf;
  int         m_drop;
  int         m_gap;

  always #5 clk = ~clk;

  ps2_keycode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .parity_ok(parity_ok), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_break(evt_break), .evt_extended(evt_extended),
    .overflow(overflow), .ovf_clear(ovf_clear), .drop_count(drop_count)
  );

  function automatic logic [10:0] obs();
    return evt_valid ? {1'b1, evt_code, evt_break, evt_extended} : 11'h0;
  endfunction

  function automatic logic [10:0] ev(bit v, logic [7:0] c, bit b, bit x);
    return v ? {1'b1, c, b, x} : 11'h0;
  endfunction

  function automatic logic [10:0] model_head();
    return (m_q.size() > 0) ? {1'b1, m_q[0]} : 11'h0;
  endfunction

  function automatic bit is_pfx(logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  // Interpret the byte against the prefix bytes collected since the last event.
  task automatic decode(input logic [7:0] b, output bit emit, output logic [9:0] e, output bit drop);
    bit has_e0, has_f0;
    emit = 0; drop = 0; e = '0; has_e0 = 0; has_f0 = 0;
    foreach (m_pend[i]) begin
      if (m_pend[i] == 8'hE0) has_e0 = 1;
      if (m_pend[i] == 8'hF0) has_f0 = 1;
    end
    if (m_pend.size() > 0 && m_pend[0] == 8'hE1) begin
      m_pend.push_back(b);
      if (m_pend.size() == 8) begin
        emit = 1; e = {8'hE1, 1'b0, 1'b1}; m_pend.delete();
      end
    end else if (has_f0) begin
      if (is_pfx(b)) drop = 1;
      else begin emit = 1; e = {b, 1'b1, has_e0}; end
      m_pend.delete();
    end else if (has_e0) begin
      if (b == 8'hE0 || b == 8'hF0) m_pend.push_back(b);
      else begin emit = 1; e = {b, 1'b0, 1'b1}; m_pend.delete(); end
    end else if (is_pfx(b)) begin
      m_pend.push_back(b);
    end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
      emit = 0;
    end else if (b == 8'h00 || b == 8'hFF) begin
      drop = 1;
    end else begin
      emit = 1; e = {b, 1'b0, 1'b0};
    end
  endtask

  // Drive one clock cycle of inputs and advance the reference model alongside.
  task automatic step(input bit bv, input logic [7:0] b, input bit par, input bit rdy, input bit clr);
    bit emit, drop, set_ovf;
    logic [9:0] e;
    @(negedge clk);
    byte_valid = bv; byte_data = b; parity_ok = par; evt_ready = rdy; ovf_clear = clr;
    emit = 0; drop = 0; set_ovf = 0; e = '0;
    if (bv) begin
      if (m_gap >= TMO) m_pend.delete();
      m_gap = 0;
      if (!par) begin drop = 1; m_pend.delete(); end
      else decode(b, emit, e, drop);
    end else begin
      m_gap++;
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (emit) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else begin drop = 1; set_ovf = 1; end
    end
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (drop && m_drop < 255) m_drop++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; byte_valid = 1; byte_data = 8'h1C; parity_ok = 1; evt_ready = 0; ovf_clear = 0;
    @(posedge clk); #1;
    reset = 0; byte_valid = 0;
    m_q.delete(); m_pend.delete(); m_ovf = 0; m_drop = 0; m_gap = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({evt_valid, evt_code, evt_break, evt_extended} !== 11'h0) begin
      errors++; $display("[TB] FAIL reset_evt: got %h expected 000", {evt_valid, evt_code, evt_break, evt_extended});
    end
    checks++;
    if ({overflow, drop_count} !== 9'h0) begin
      errors++; $display("[TB] FAIL reset_status: got ovf=%b drop=%0d expected 0/0", overflow, drop_count);
    end
    step(0, 8'h00, 1, 0, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_byte_ignored: got evt_valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_make();
    do_reset();
    step(1, 8'h1C, 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'h1C, 0, 0)) begin
      errors++; $display("[TB] FAIL make_latency: got %h expected %h", obs(), ev(1, 8'h1C, 0, 0));
    end
    step(0, 8'h00, 1, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL make_pop_empty: got evt_valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_break_ext();
    do_reset();
    step(1, 8'hF0, 1, 0, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL break_prefix_only: got evt_valid=%b expected 0", evt_valid);
    end
    step(1, 8'h1C, 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'h1C, 1, 0)) begin
      errors++; $display("[TB] FAIL break_code: got %h expected %h", obs(), ev(1, 8'h1C, 1, 0));
    end
    step(1, 8'hE0, 1, 1, 0);
    step(1, 8'hF0, 1, 0, 0);
    step(1, 8'h75, 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'h75, 1, 1)) begin
      errors++; $display("[TB] FAIL ext_break_code: got %h expected %h", obs(), ev(1, 8'h75, 1, 1));
    end
    step(1, 8'hE0, 1, 1, 0);
    repeat (3) step(0, 8'h00, 1, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL ext_alone: got evt_valid=%b expected 0", evt_valid);
    end
    step(1, 8'h74, 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'h74, 0, 1)) begin
      errors++; $display("[TB] FAIL ext_make: got %h expected %h", obs(), ev(1, 8'h74, 0, 1));
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int early;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    early = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, seq[i], 1, 0, 0);
      if (evt_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("[TB] FAIL pause_early: got %0d early events expected 0", early);
    end
    step(1, seq[7], 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'hE1, 0, 1)) begin
      errors++; $display("[TB] FAIL pause_event: got %h expected %h", obs(), ev(1, 8'hE1, 0, 1));
    end
    step(0, 8'h00, 1, 1, 0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_single: got evt_valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
    do_reset();
    for (int i = 0; i < 5; i++) step(1, codes[i], 1, 0, 0);
    checks++;
    if ({overflow, drop_count} !== {1'b1, 8'd1}) begin
      errors++; $display("[TB] FAIL ovf_set: got ovf=%b drop=%0d expected 1/1", overflow, drop_count);
    end
    step(0, 8'h00, 1, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow);
    end
    step(1, 8'h2E, 1, 0, 1);
    checks++;
    if ({overflow, drop_count} !== {1'b1, 8'd2}) begin
      errors++; $display("[TB] FAIL ovf_set_beats_clear: got ovf=%b drop=%0d expected 1/2", overflow, drop_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== ev(1, codes[i], 0, 0)) begin
        errors++; $display("[TB] FAIL ovf_order_%0d: got %h expected %h", i, obs(), ev(1, codes[i], 0, 0));
      end
      step(0, 8'h00, 1, 1, 0);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_drain: got evt_valid=%b expected 0", evt_valid);
    end
    // Full FIFO with a simultaneous pop must accept the new event.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, codes[i], 1, 0, 0);
    step(1, codes[4], 1, 1, 0);
    checks++;
    if ({overflow, drop_count, obs()} !== {1'b0, 8'd0, ev(1, codes[1], 0, 0)}) begin
      errors++; $display("[TB] FAIL full_push_pop: got ovf=%b drop=%0d head=%h expected 0/0/%h",
                         overflow, drop_count, obs(), ev(1, codes[1], 0, 0));
    end
    for (int i = 2; i < 5; i++) begin
      step(0, 8'h00, 1, 1, 0);
      checks++;
      if (obs() !== ev(1, codes[i], 0, 0)) begin
        errors++; $display("[TB] FAIL full_push_pop_order_%0d: got %h expected %h", i, obs(), ev(1, codes[i], 0, 0));
      end
    end
  endtask

  task automatic test_timeout_parity();
    do_reset();
    step(1, 8'hE0, 1, 0, 0);
    repeat (TMO) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h74, 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'h74, 0, 0)) begin
      errors++; $display("[TB] FAIL timeout_abandon: got %h expected %h", obs(), ev(1, 8'h74, 0, 0));
    end
    step(1, 8'hE0, 1, 1, 0);
    repeat (TMO - 1) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h74, 1, 0, 0);
    checks++;
    if ({obs(), drop_count} !== {ev(1, 8'h74, 0, 1), 8'd0}) begin
      errors++; $display("[TB] FAIL timeout_not_yet: got %h drop=%0d expected %h drop=0", obs(), drop_count, ev(1, 8'h74, 0, 1));
    end
    step(1, 8'hF0, 0, 1, 0);
    step(1, 8'h1C, 1, 0, 0);
    checks++;
    if ({obs(), drop_count} !== {ev(1, 8'h1C, 0, 0), 8'd1}) begin
      errors++; $display("[TB] FAIL parity_err: got %h drop=%0d expected %h drop=1", obs(), drop_count, ev(1, 8'h1C, 0, 0));
    end
  endtask

  task automatic test_acks_reset();
    do_reset();
    step(1, 8'hAA, 1, 0, 0);
    step(1, 8'hFA, 1, 0, 0);
    checks++;
    if ({evt_valid, drop_count} !== 9'h0) begin
      errors++; $display("[TB] FAIL ack_silent: got valid=%b drop=%0d expected 0/0", evt_valid, drop_count);
    end
    step(1, 8'h00, 1, 0, 0);
    checks++;
    if ({evt_valid, drop_count} !== {1'b0, 8'd1}) begin
      errors++; $display("[TB] FAIL zero_byte: got valid=%b drop=%0d expected 0/1", evt_valid, drop_count);
    end
    step(1, 8'hF0, 1, 0, 0);
    do_reset();
    step(1, 8'h1C, 1, 0, 0);
    checks++;
    if (obs() !== ev(1, 8'h1C, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_mid_seq: got %h expected %h", obs(), ev(1, 8'h1C, 0, 0));
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (254) step(1, 8'hFF, 1, 0, 0);
    checks++;
    if (drop_count !== 8'd254) begin
      errors++; $display("[TB] FAIL drop_254: got %0d expected 254", drop_count);
    end
    repeat (6) step(1, 8'h00, 1, 0, 0);
    checks++;
    if (drop_count !== 8'd255) begin
      errors++; $display("[TB] FAIL drop_saturate: got %0d expected 255", drop_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] acks [4];
    int r, bad;
    acks = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};
    do_reset();
    bad = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      if ($urandom_range(0, 79) == 0) begin
        repeat (TMO - 2 + $urandom_range(0, 3)) step(0, 8'h00, 1, $urandom_range(0, 1), 0);
      end
      r = $urandom_range(0, 15);
      if (r < 3)       b = 8'hE0;
      else if (r < 5)  b = 8'hF0;
      else if (r == 5) b = 8'hE1;
      else if (r == 6) b = acks[$urandom_range(0, 3)];
      else if (r == 7) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else             b = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
      checks++;
      if ({obs(), overflow, drop_count} !== {model_head(), m_ovf, 8'(m_drop)}) begin
        errors++;
        $display("[TB] FAIL random_%0d: got head=%h ovf=%b drop=%0d expected head=%h ovf=%b drop=%0d",
                 n, obs(), overflow, drop_count, model_head(), m_ovf, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break_ext();
    test_pause();
    test_overflow();
    test_timeout_parity();
    test_acks_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
